// File: rtl/pipe_ready.sv
// Ready-path register slice with a one-beat skid buffer: 0-cycle latency when empty, 1 when skidded.
// ready_up comes straight from a flop; a stalled accepted beat parks in the skid register.
module pipe_ready #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              valid_up,
    input  logic [DATA_W-1:0] data_up,
    output logic              ready_up,
    output logic              valid_middle,
    output logic [DATA_W-1:0] data_middle,
    input  logic              ready_middle,
    output logic              skid_full,
    output logic [CNT_W-1:0]  xfer_cnt
);

    typedef enum logic {PASS = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q;
    logic               up_hs;
    logic               dn_hs;

    always_comb begin
        up_hs   = valid_up && ready_q;
        state_d = state_q;
        skid_d  = skid_q;
        if (state_q == FULL) begin
            valid_middle = 1'b1;
            data_middle  = skid_q;
            if (ready_middle) state_d = PASS;
        end else begin
            valid_middle = up_hs;
            data_middle  = data_up;
            // An accepted beat that downstream refuses must be parked this edge.
            if (up_hs && !ready_middle) begin
                state_d = FULL;
                skid_d  = data_up;
            end
        end
        dn_hs = valid_middle && ready_middle;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, dn_hs};
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PASS;
            skid_q  <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            skid_q  <= skid_d;
            ready_q <= (state_d == PASS);
            cnt_q   <= cnt_d;
        end
    end

    assign ready_up  = ready_q;
    assign skid_full = (state_q == FULL);
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_ready.sv
// Self-checking bench for pipe_ready: vector table, hand sequences and an in-order scoreboard.
module tb_pipe_ready;

    logic       sys_clk;
    logic       rst_n;
    logic       valid_up;
    logic [2:0] data_up;
    logic       ready_up;
    logic       valid_middle;
    logic [2:0] data_middle;
    logic       ready_middle;
    logic       skid_full;
    logic [7:0] xfer_cnt;

    pipe_ready #(.DATA_W(3), .CNT_W(8)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .valid_up     (valid_up),
        .data_up      (data_up),
        .ready_up     (ready_up),
        .valid_middle (valid_middle),
        .data_middle  (data_middle),
        .ready_middle (ready_middle),
        .skid_full    (skid_full),
        .xfer_cnt     (xfer_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic       rm;
        logic       vm;
        logic [2:0] dm;
        logic       ru;
        logic       sf;
    } vec_t;

    vec_t       tbl [10];
    logic [2:0] sb [$];
    logic [7:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard: accepted beats queued, delivered beats popped in order.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            chk("xfer_cnt", xfer_cnt, exp_cnt);
            chk("skid_vs_ready", skid_full & ready_up, 0);
            if (valid_up && ready_up) sb.push_back(data_up);
            if (valid_middle && ready_middle) begin
                exp_cnt = exp_cnt + 8'd1;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: delivered %0d with nothing pending at %0t", data_middle, $time);
                end else begin
                    chk("sb_data", data_middle, sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        valid_up     = 1'b0;
        data_up      = 3'd0;
        ready_middle = 1'b0;

        //              v   d     rm  vm  dm    ru  sf
        tbl[0] = '{1'b1, 3'd1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 3'd4, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 3'd7, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 3'd3, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1};
        tbl[9] = '{1'b1, 3'd6, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0};

        // Reset values, then first beat after release
        valid_up     = 1'b1;
        data_up      = 3'd5;
        ready_middle = 1'b1;
        tick();
        tick();
        chk("rst_ready_up", ready_up, 0);
        chk("rst_valid_middle", valid_middle, 0);
        chk("rst_skid_full", skid_full, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        chk("rst_data_middle", data_middle, 5);
        rst_n = 1'b1;
        #3;
        chk("c1_ready_up", ready_up, 0);
        chk("c1_valid_middle", valid_middle, 0);
        tick();
        #3;
        chk("c2_valid_middle", valid_middle, 1);
        chk("c2_data_middle", data_middle, 5);
        chk("c2_ready_up", ready_up, 1);
        tick();
        valid_up = 1'b0;
        #3;
        chk("c3_xfer_cnt", xfer_cnt, 1);

        // Streaming 0..7 with downstream always ready
        do_reset();
        for (int i = 0; i < 8; i++) begin
            valid_up     = 1'b1;
            data_up      = 3'(i);
            ready_middle = 1'b1;
            #3;
            chk("stream_data", data_middle, i);
            chk("stream_ready_up", ready_up, 1);
            chk("stream_valid", valid_middle, 1);
            tick();
        end
        valid_up = 1'b0;
        #3;
        chk("stream_cnt", xfer_cnt, 8);
        tick();

        // Vector table: pass-through, idle, skid capture, simultaneous release
        for (int i = 0; i < 10; i++) begin
            valid_up     = tbl[i].v;
            data_up      = tbl[i].d;
            ready_middle = tbl[i].rm;
            #3;
            chk($sformatf("vec%0d_valid_middle", i), valid_middle, tbl[i].vm);
            chk($sformatf("vec%0d_data_middle", i), data_middle, tbl[i].dm);
            chk($sformatf("vec%0d_ready_up", i), ready_up, tbl[i].ru);
            chk($sformatf("vec%0d_skid_full", i), skid_full, tbl[i].sf);
            tick();
        end
        valid_up = 1'b0;
        tick();

        // Reset while a beat (6) sits in the skid register
        valid_up     = 1'b1;
        data_up      = 3'd6;
        ready_middle = 1'b0;
        tick();
        valid_up = 1'b0;
        data_up  = 3'd0;
        #3;
        chk("full_skid_full", skid_full, 1);
        chk("full_data_middle", data_middle, 6);
        chk("full_ready_up", ready_up, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_skid_full", skid_full, 0);
        chk("arst_ready_up", ready_up, 0);
        chk("arst_valid_middle", valid_middle, 0);
        chk("arst_xfer_cnt", xfer_cnt, 0);
        chk("arst_data_middle", data_middle, 0);
        tick();
        rst_n        = 1'b1;
        ready_middle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("post_rst_no_beat", valid_middle, 0);
            tick();
        end

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            valid_up     = 1'($urandom_range(0, 1));
            data_up      = 3'($urandom_range(0, 7));
            ready_middle = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_up     = 1'b0;
        ready_middle = 1'b1;
        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);

        // Counter wrap after 256 transfers
        do_reset();
        valid_up     = 1'b1;
        ready_middle = 1'b1;
        repeat (255) tick();
        #3;
        chk("cnt_255", xfer_cnt, 255);
        tick();
        valid_up = 1'b0;
        #3;
        chk("cnt_wrap", xfer_cnt, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ready.md
PIPE_READY -- requirements
Module: pipe_ready

Interface
REQ-001 Parameter: DATA_W, default 3, payload width in bits.
REQ-002 Parameter: CNT_W, default 8, width of the transfer counter.
REQ-003 Port: sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset; asserting it clears all state immediately, with no clock edge needed.
REQ-005 Port: valid_up  input  1  upstream beat valid.
REQ-006 Port: data_up  input  DATA_W  upstream payload.
REQ-007 Port: ready_up  output  1  registered ready to upstream; driven directly from a flop, with no combinational path from ready_middle.
REQ-008 Port: valid_middle  output  1  beat valid to downstream.
REQ-009 Port: data_middle  output  DATA_W  payload to downstream.
REQ-010 Port: ready_middle  input  1  downstream ready.
REQ-011 Port: skid_full  output  1  high while the skid register holds a beat.
REQ-012 Port: xfer_cnt  output  CNT_W  count of downstream transfers (valid_middle && ready_middle).

Function
REQ-013 Block SHALL register the ready path (backward direction): the downstream ready timing is cut at ready_up, and valid/data pass forward combinationally when the skid register is empty.
REQ-014 Upstream handshake SHALL occur when valid_up && ready_up; downstream handshake SHALL occur when valid_middle && ready_middle.
REQ-015 State machine SHALL have two states: PASS (skid empty, skid_full=0) and FULL (skid holds a beat, skid_full=1).
REQ-016 PASS outputs: valid_middle = valid_up && ready_up; data_middle = data_up.
REQ-017 FULL outputs: valid_middle = 1; data_middle = skid data register.
REQ-018 PASS -> FULL transition: when an upstream handshake occurs and ready_middle=0, data_up SHALL be captured into the skid register at the same edge.
REQ-019 PASS stays in PASS in all other cases; the skid register is not written.
REQ-020 FULL -> PASS transition: when ready_middle=1, the skid beat is delivered that cycle.
REQ-021 FULL stays in FULL while ready_middle=0; skid data SHALL remain stable.
REQ-022 ready_up SHALL be registered as the inverse of the next-state skid_full: ready_up=0 on the cycle after PASS -> FULL, and ready_up=1 on the cycle after FULL -> PASS.
REQ-023 In FULL, ready_up=0, so no upstream beat SHALL be accepted; at most one beat is ever buffered.
REQ-024 Latency SHALL be 0 cycles in PASS and 1 cycle minimum for a skidded beat.
REQ-025 Beat order SHALL be preserved, with no loss and no duplication.
REQ-026 Throughput SHALL be 1 beat/cycle while ready_middle stays high.
REQ-027 Each ready_middle low pulse that skids a beat costs exactly one upstream bubble cycle.
REQ-028 xfer_cnt SHALL increment by 1 on every downstream handshake.
REQ-029 xfer_cnt SHALL wrap modulo 2^CNT_W (255 -> 0 at default width) without saturating.
REQ-030 Simultaneous events in FULL: when ready_middle=1 and valid_up=1 in the same cycle, the skid beat is delivered and the upstream beat is not accepted (ready_up=0); that beat is accepted one cycle later.
REQ-031 valid_up low in PASS SHALL produce valid_middle=0, regardless of ready_middle.

Reset
REQ-032 On rst_n=0: state=PASS, skid_full=0, ready_up=0, valid_middle=0, skid data=0, data_middle=data_up, xfer_cnt=0.
REQ-033 ready_up SHALL rise on the first rising edge after rst_n deasserts.
REQ-034 Reset asserted while in FULL SHALL discard the buffered beat; no partial state survives.

Verification
REQ-035 Reset release, valid_up=1, data_up=3'd5, ready_middle=1 -> cycle 1: ready_up=0, valid_middle=0; cycle 2: valid_middle=1, data_middle=5, xfer_cnt=1 after the edge.
REQ-036 Streaming 0..7 with ready_middle held 1 -> data_middle=0..7 on consecutive cycles, ready_up constantly 1, xfer_cnt=8.
REQ-037 Beat 3'd2 accepted while ready_middle=0 -> next cycle skid_full=1, ready_up=0, data_middle=2 held; ready_middle=1 -> 2 delivered, then upstream beat 3'd3 accepted one cycle later; no beat lost.
REQ-038 Random valid_up and ready_middle for 10k cycles against a scoreboard -> sequence matches in order, no drops or duplicates, skid_full never set while ready_up=1 at the same edge.
REQ-039 Reset pulsed while skid_full=1 holding 3'd6 -> all outputs reach their reset values, and 6 is never delivered after reset.
REQ-040 256 downstream transfers -> xfer_cnt wraps 255 -> 0.
